// File: rtl/front_panel_io_if.sv
// CPU-side register bus of the SBC6502 front-panel controller.
// The CPU board drives the master side; front_panel_io is the slave.
interface front_panel_io_if;
    logic       CS;
    logic       WE;
    logic [4:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       IRQ;

    modport master (output CS, WE, ADDR, DIN, input DOUT, IRQ);
    modport slave  (input CS, WE, ADDR, DIN, output DOUT, IRQ);
endinterface

// File: rtl/front_panel_io.sv
// Memory-mapped front-panel controller for the SBC6502 board: CPU-writable
// 7-segment digits (raw or hex-decoded), LED and switch registers, debounced
// keys with sticky press events and a level interrupt.
// Optional digit blinking is built only when FRONT_PANEL_BLINK_EN is defined.
module front_panel_io #(
    parameter int unsigned SYSCLK_MHZ  = 50,
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned NUM_LEDS    = 10,
    parameter int unsigned NUM_SW      = 10,
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned BLINK_MS    = 250
) (
    input  logic                    CLK,
    input  logic                    RESET,
    front_panel_io_if.slave         bus,
    input  logic [NUM_SW-1:0]       SW,
    input  logic [NUM_KEYS-1:0]     KEY,
    output logic [NUM_LEDS-1:0]     LEDR,
    output logic [NUM_DIGITS*8-1:0] HEX
);

    localparam int unsigned TICK_CYC = SYSCLK_MHZ * 1000;
    localparam int unsigned PW       = $clog2(TICK_CYC);
    localparam int unsigned LO_LED   = (NUM_LEDS < 8) ? NUM_LEDS : 8;
    localparam int unsigned HI_LED   = (NUM_LEDS > 8) ? NUM_LEDS - 8 : 0;
    localparam int unsigned LO_SW    = (NUM_SW < 8) ? NUM_SW : 8;
    localparam int unsigned HI_SW    = (NUM_SW > 8) ? NUM_SW - 8 : 0;

    localparam logic [4:0] A_LED_LO   = 5'd0;
    localparam logic [4:0] A_LED_HI   = 5'd1;
    localparam logic [4:0] A_SW_LO    = 5'd2;
    localparam logic [4:0] A_SW_HI    = 5'd3;
    localparam logic [4:0] A_KEY_STAT = 5'd4;
    localparam logic [4:0] A_KEY_EVT  = 5'd5;
    localparam logic [4:0] A_KEY_IE   = 5'd6;
    localparam logic [4:0] A_HEX_MODE = 5'd7;
    localparam logic [4:0] A_DIGIT0   = 5'd8;
`ifdef FRONT_PANEL_BLINK_EN
    localparam logic [4:0] A_BLINK    = 5'd16;
    localparam int unsigned BW        = $clog2(BLINK_MS + 1);
`endif

    generate
        if (SYSCLK_MHZ < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
            NUM_LEDS < 1 || NUM_LEDS > 16 || NUM_SW < 1 || NUM_SW > 16 ||
            NUM_KEYS < 1 || NUM_KEYS > 8 || DEBOUNCE_MS < 1 ||
            DEBOUNCE_MS > 255 || BLINK_MS < 1) begin : g_bad_param
            $error("front_panel_io: parameter out of range");
        end
    endgenerate

    function automatic logic [6:0] seg_dec(input logic [3:0] v);
        case (v)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    endfunction

    logic [PW-1:0]           pre_cnt;
    logic                    tick;
    logic [NUM_SW-1:0]       sw_m, sw_s;
    logic [NUM_KEYS-1:0]     key_m, key_s;
    logic [7:0]              deb_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]     key_deb, deb_done, key_press;
    logic [NUM_KEYS-1:0]     key_evt, key_ie, evt_clr;
    logic [NUM_DIGITS-1:0]   hex_mode, blank;
    logic [7:0]              digit [NUM_DIGITS];
    logic [NUM_DIGITS*8-1:0] hex_next;
    logic [7:0]              rd_data;
    logic                    wr, rd;

    assign wr   = bus.CS & bus.WE;
    assign rd   = bus.CS & ~bus.WE;
    assign tick = (pre_cnt == PW'(TICK_CYC - 1));

    // Free-running millisecond prescaler
    always_ff @(posedge CLK) begin
        if (RESET || tick) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
    end

    // Two-flop synchronizers; keys are inverted so 1 = pressed
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_m  <= '0;
            sw_s  <= '0;
            key_m <= '0;
            key_s <= '0;
        end else begin
            sw_m  <= SW;
            sw_s  <= sw_m;
            key_m <= ~KEY;
            key_s <= key_m;
        end
    end

    // Keys whose stable window completes this cycle, and which of those are presses
    always_comb begin
        for (int unsigned n = 0; n < NUM_KEYS; n++)
            deb_done[n] = tick && (key_s[n] != key_deb[n]) &&
                          (deb_cnt[n] == 8'(DEBOUNCE_MS - 1));
        key_press = deb_done & key_s;
    end

    // Per-key debounce: any sample matching the accepted level restarts the window
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_deb <= '0;
            for (int unsigned n = 0; n < NUM_KEYS; n++) deb_cnt[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_KEYS; n++) begin
                if (key_s[n] == key_deb[n]) begin
                    deb_cnt[n] <= '0;
                end else if (deb_done[n]) begin
                    deb_cnt[n] <= '0;
                    key_deb[n] <= key_s[n];
                end else if (tick) begin
                    deb_cnt[n] <= deb_cnt[n] + 8'd1;
                end
            end
        end
    end

    assign evt_clr = (wr && bus.ADDR == A_KEY_EVT) ? bus.DIN[NUM_KEYS-1:0] : '0;

    // CPU-writable registers; a press landing with a clear of the same bit keeps it set
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LEDR     <= '0;
            key_evt  <= '0;
            key_ie   <= '0;
            hex_mode <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= 8'hBF;
        end else begin
            key_evt <= (key_evt & ~evt_clr) | key_press;
            if (wr) begin
                if (bus.ADDR == A_LED_LO)
                    for (int unsigned i = 0; i < LO_LED; i++) LEDR[i] <= bus.DIN[i];
                if (bus.ADDR == A_LED_HI)
                    for (int unsigned i = 0; i < HI_LED; i++) LEDR[8+i] <= bus.DIN[i];
                if (bus.ADDR == A_KEY_IE)
                    key_ie <= bus.DIN[NUM_KEYS-1:0];
                if (bus.ADDR == A_HEX_MODE)
                    hex_mode <= bus.DIN[NUM_DIGITS-1:0];
                for (int unsigned i = 0; i < NUM_DIGITS; i++)
                    if (bus.ADDR == A_DIGIT0 + 5'(i)) digit[i] <= bus.DIN;
            end
        end
    end

    // Interrupt request from enabled sticky events
    always_ff @(posedge CLK) begin
        if (RESET) bus.IRQ <= 1'b0;
        else       bus.IRQ <= |(key_evt & key_ie);
    end

`ifdef FRONT_PANEL_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;

    // Blink mask register and half-period phase counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink_mask  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr && bus.ADDR == A_BLINK) blink_mask <= bus.DIN[NUM_DIGITS-1:0];
            if (tick) begin
                if (blink_cnt == BW'(BLINK_MS - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign blank = blink_phase ? blink_mask : '0;
`else
    assign blank = '0;
`endif

    // Segment pattern per digit: blanked, hex-decoded or raw
    always_comb begin
        hex_next = '0;
        for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
            if (blank[n])         hex_next[8*n +: 8] = 8'hFF;
            else if (hex_mode[n]) hex_next[8*n +: 8] = {~digit[n][7], seg_dec(digit[n][3:0])};
            else                  hex_next[8*n +: 8] = digit[n];
        end
    end

    // Registered segment outputs
    always_ff @(posedge CLK) begin
        if (RESET) HEX <= {NUM_DIGITS{8'hBF}};
        else       HEX <= hex_next;
    end

    // Read multiplexer; unimplemented bits and addresses return 0
    always_comb begin
        rd_data = '0;
        if (bus.ADDR == A_LED_LO)
            for (int unsigned i = 0; i < LO_LED; i++) rd_data[i] = LEDR[i];
        if (bus.ADDR == A_LED_HI)
            for (int unsigned i = 0; i < HI_LED; i++) rd_data[i] = LEDR[8+i];
        if (bus.ADDR == A_SW_LO)
            for (int unsigned i = 0; i < LO_SW; i++) rd_data[i] = sw_s[i];
        if (bus.ADDR == A_SW_HI)
            for (int unsigned i = 0; i < HI_SW; i++) rd_data[i] = sw_s[8+i];
        if (bus.ADDR == A_KEY_STAT)
            for (int unsigned i = 0; i < NUM_KEYS; i++) rd_data[i] = key_deb[i];
        if (bus.ADDR == A_KEY_EVT)
            for (int unsigned i = 0; i < NUM_KEYS; i++) rd_data[i] = key_evt[i];
        if (bus.ADDR == A_KEY_IE)
            for (int unsigned i = 0; i < NUM_KEYS; i++) rd_data[i] = key_ie[i];
        if (bus.ADDR == A_HEX_MODE)
            for (int unsigned i = 0; i < NUM_DIGITS; i++) rd_data[i] = hex_mode[i];
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (bus.ADDR == A_DIGIT0 + 5'(i)) rd_data = digit[i];
`ifdef FRONT_PANEL_BLINK_EN
        if (bus.ADDR == A_BLINK)
            for (int unsigned i = 0; i < NUM_DIGITS; i++) rd_data[i] = blink_mask[i];
`endif
    end

    // Registered read data, held between reads
    always_ff @(posedge CLK) begin
        if (RESET)   bus.DOUT <= '0;
        else if (rd) bus.DOUT <= rd_data;
    end

endmodule
